// File: rtl/stp_count_min_sec_if.sv
// Stopwatch min/sec control and display bundle.
// The master drives the control pulses; the slave returns the time.
interface stp_count_min_sec_if;
  logic       start;
  logic       pause;
  logic       stop;
  logic       rst_counters;
  logic       lap;
  logic [7:0] cs;
  logic [7:0] sec;
  logic [7:0] min;
  logic       count_up_hr;
  logic       running;
  logic [7:0] lap_cs;
  logic [7:0] lap_sec;
  logic [7:0] lap_min;
  logic       lap_valid;

  modport master (
    output start, pause, stop, rst_counters, lap,
    input  cs, sec, min, count_up_hr, running,
    input  lap_cs, lap_sec, lap_min, lap_valid
  );

  modport slave (
    input  start, pause, stop, rst_counters, lap,
    output cs, sec, min, count_up_hr, running,
    output lap_cs, lap_sec, lap_min, lap_valid
  );
endinterface

// File: rtl/stp_count_min_sec.sv
// Stopwatch prescaler, cs/sec/min chain and start/pause/stop FSM.
// Lap capture is built only when STP_LAP_EN is defined.
module stp_count_min_sec #(
  parameter int TICK_DIV = 500000
) (
  input logic                 CLK,
  input logic                 rst,
  stp_count_min_sec_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  state_t        r_state;
  logic          r_running;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_cs;
  logic [7:0]    r_sec;
  logic [7:0]    r_min;
  logic          r_hr;

  logic w_clr;
  logic w_tick;
  logic w_cs_wrap;
  logic w_sec_wrap;
  logic w_min_wrap;

  assign w_clr      = bus.stop | bus.rst_counters;
  assign w_tick     = (r_state == RUN) && (r_pre == PRE_MAX);
  assign w_cs_wrap  = (r_cs == 8'd99);
  assign w_sec_wrap = (r_sec == 8'd59);
  assign w_min_wrap = (r_min == 8'd59);

  // Counter chain: a clear on the same edge discards any tick.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_cs  <= '0;
      r_sec <= '0;
      r_min <= '0;
      r_hr  <= 1'b0;
    end else begin
      r_hr <= 1'b0;
      if (w_clr) begin
        r_pre <= '0;
        r_cs  <= '0;
        r_sec <= '0;
        r_min <= '0;
      end else if (r_state == RUN) begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        if (w_tick) begin
          r_cs <= w_cs_wrap ? 8'd0 : r_cs + 8'd1;
          if (w_cs_wrap) begin
            r_sec <= w_sec_wrap ? 8'd0 : r_sec + 8'd1;
            if (w_sec_wrap) begin
              r_min <= w_min_wrap ? 8'd0 : r_min + 8'd1;
              r_hr  <= w_min_wrap;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else if (bus.stop) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else if (!bus.rst_counters) begin
      unique case (r_state)
        IDLE, PAUSED: begin
          if (bus.start) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (bus.pause) begin
            r_state   <= PAUSED;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cs          = r_cs;
  assign bus.sec         = r_sec;
  assign bus.min         = r_min;
  assign bus.count_up_hr = r_hr;
  assign bus.running     = r_running;

`ifdef STP_LAP_EN
  logic [7:0] r_lap_cs;
  logic [7:0] r_lap_sec;
  logic [7:0] r_lap_min;
  logic       r_lap_valid;

  // Captures the pre-edge time, so a coincident tick is not seen.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_lap_cs    <= '0;
      r_lap_sec   <= '0;
      r_lap_min   <= '0;
      r_lap_valid <= 1'b0;
    end else if (w_clr) begin
      r_lap_cs    <= '0;
      r_lap_sec   <= '0;
      r_lap_min   <= '0;
      r_lap_valid <= 1'b0;
    end else if (bus.lap && r_state != IDLE) begin
      r_lap_cs    <= r_cs;
      r_lap_sec   <= r_sec;
      r_lap_min   <= r_min;
      r_lap_valid <= 1'b1;
    end
  end

  assign bus.lap_cs    = r_lap_cs;
  assign bus.lap_sec   = r_lap_sec;
  assign bus.lap_min   = r_lap_min;
  assign bus.lap_valid = r_lap_valid;
`else
  assign bus.lap_cs    = '0;
  assign bus.lap_sec   = '0;
  assign bus.lap_min   = '0;
  assign bus.lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stp_count_min_sec.sv
// Bench for stp_count_min_sec: random pulses against a model that
// tracks elapsed time as a single centisecond count.
module tb_stp_count_min_sec;

  localparam int DIV  = 4;
  localparam int HOUR = 360000;
`ifdef STP_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  stp_count_min_sec_if b ();

  stp_count_min_sec #(.TICK_DIV(DIV)) dut (
    .CLK (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // model: 0 idle, 1 run, 2 paused
  int m_state;
  int m_pre;
  int m_t;
  int m_lt;
  bit m_lv;
  bit m_hr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void m_clr();
    m_pre = 0;
    m_t   = 0;
    m_lt  = 0;
    m_lv  = 1'b0;
  endfunction

  function automatic void m_step(input bit st, input bit pa,
                                 input bit sp, input bit rc,
                                 input bit lp);
    m_hr = 1'b0;
    if (sp) begin
      m_clr();
      m_state = 0;
    end else if (rc) begin
      m_clr();
    end else begin
      if (LAP_EN && lp && m_state != 0) begin
        m_lt = m_t;
        m_lv = 1'b1;
      end
      if (m_state == 1) begin
        m_pre++;
        if (m_pre == DIV) begin
          m_pre = 0;
          m_t++;
          if (m_t == HOUR) begin
            m_t  = 0;
            m_hr = 1'b1;
          end
        end
      end
      if (m_state == 1 && pa) m_state = 2;
      else if (m_state != 1 && st) m_state = 1;
    end
  endfunction

  task automatic cmp_all();
    chk("cs", b.cs, m_t % 100);
    chk("sec", b.sec, (m_t / 100) % 60);
    chk("min", b.min, m_t / 6000);
    chk("count_up_hr", b.count_up_hr, m_hr);
    chk("running", b.running, m_state == 1);
    chk("lap_cs", b.lap_cs, m_lt % 100);
    chk("lap_sec", b.lap_sec, (m_lt / 100) % 60);
    chk("lap_min", b.lap_min, m_lt / 6000);
    chk("lap_valid", b.lap_valid, m_lv);
  endtask

  task automatic cyc(input bit st, input bit pa, input bit sp,
                     input bit rc, input bit lp);
    @(negedge clk);
    b.start        = st;
    b.pause        = pa;
    b.stop         = sp;
    b.rst_counters = rc;
    b.lap          = lp;
    m_step(st, pa, sp, rc, lp);
    @(posedge clk);
    #1;
    b.start        = 1'b0;
    b.pause        = 1'b0;
    b.stop         = 1'b0;
    b.rst_counters = 1'b0;
    b.lap          = 1'b0;
    cmp_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Loads a time into the held counters; only used while paused.
  task automatic preset(input int t);
    logic [7:0] v_cs, v_sec, v_min;
    v_cs  = 8'(t % 100);
    v_sec = 8'((t / 100) % 60);
    v_min = 8'(t / 6000);
    @(negedge clk);
    force dut.r_cs  = v_cs;
    force dut.r_sec = v_sec;
    force dut.r_min = v_min;
    m_step(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    release dut.r_cs;
    release dut.r_sec;
    release dut.r_min;
    m_t = t;
    cmp_all();
  endtask

  task automatic restart_paused();
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(2);
    cyc(0, 1, 0, 0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    n_chk  = 0;
    n_fail = 0;
    b.start        = 1'b0;
    b.pause        = 1'b0;
    b.stop         = 1'b0;
    b.rst_counters = 1'b0;
    b.lap          = 1'b0;
    m_state = 0;
    m_hr    = 1'b0;
    m_clr();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_all();
    @(negedge clk);
    rst = 1'b0;

    // one second at DIV=4
    cyc(1, 0, 0, 0, 0);
    idle(400);
    chk("one_sec_sec", b.sec, 1);
    chk("one_sec_cs", b.cs, 0);
    chk("one_sec_run", b.running, 1);

    // pause holds sub-centisecond phase
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    k = 0;
    while (!(m_t == 5 && m_pre == 2) && k < 100) begin
      idle(1);
      k++;
    end
    chk("reach_cs5", k < 100, 1);
    cyc(0, 1, 0, 0, 0);
    idle(100);
    chk("pause_hold_cs", b.cs, 5);
    cyc(1, 0, 0, 0, 0);
    idle(1);
    chk("resume_cs", b.cs, 6);

    // 59:59.98 rollover and single hour pulse
    restart_paused();
    preset(HOUR - 2);
    cyc(1, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (b.count_up_hr) begin
        n++;
        chk("hr_at_zero", {b.min, b.sec, b.cs}, 0);
      end
    end
    chk("hr_pulses", n, 1);

    // stop on the wrapping tick drops the rollover
    restart_paused();
    preset(HOUR - 1);
    cyc(1, 0, 0, 0, 0);
    k = 0;
    while (!(m_state == 1 && m_pre == DIV - 1) && k < 8) begin
      idle(1);
      k++;
    end
    cyc(0, 0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (b.count_up_hr) n++;
      idle(1);
    end
    chk("stop_wrap_hr", n, 0);
    chk("stop_wrap_time", {b.min, b.sec, b.cs}, 0);
    chk("stop_wrap_run", b.running, 0);

    // rst_counters in RUN keeps running
    restart_paused();
    preset(1234);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("rc_cs", b.cs, 0);
    chk("rc_run", b.running, 1);
    idle(20);
    chk("rc_continue", b.cs, 5);

    // lap at 00:03.07
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    k = 0;
    while (m_t != 307 && k < 2000) begin
      idle(1);
      k++;
    end
    cyc(0, 0, 0, 0, 1);
    chk("lap_sec_val", b.lap_sec, LAP_EN ? 3 : 0);
    chk("lap_cs_val", b.lap_cs, LAP_EN ? 7 : 0);
    chk("lap_valid_set", b.lap_valid, LAP_EN);
    cyc(0, 0, 1, 0, 0);
    chk("lap_valid_clr", b.lap_valid, 0);

    // random pulses, one per cycle at most
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)       cyc(0, 0, 1, 0, 0);
      else if (r < 4)  cyc(0, 0, 0, 1, 0);
      else if (r < 9)  cyc(0, 1, 0, 0, 0);
      else if (r < 15) cyc(1, 0, 0, 0, 0);
      else if (r < 20) cyc(0, 0, 0, 0, 1);
      else             cyc(0, 0, 0, 0, 0);
      if (i == 1500) begin
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        m_state = 0;
        m_hr    = 1'b0;
        m_clr();
        cmp_all();
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
